// File: rtl/serial_parity_pkg.sv
// Shared constants for the serial parity generator/checker: FSM encoding and the
// legal DATA_W range.
package serial_parity_pkg;

  localparam logic [1:0] StateIdleEnc  = 2'd0;
  localparam logic [1:0] StateAccumEnc = 2'd1;
  localparam logic [1:0] StateCheckEnc = 2'd2;
  localparam logic [1:0] StateDoneEnc  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = StateIdleEnc,
    StAccum = StateAccumEnc,
    StCheck = StateCheckEnc,
    StDone  = StateDoneEnc
  } state_e;

  localparam int unsigned DataWMin = 2;
  localparam int unsigned DataWMax = 255;

endpackage

// File: rtl/serial_parity_fsm_if.sv
// Frame handshake and result bundle of serial_parity_fsm.
// par_err exists only when SERIAL_PARITY_CHECK_EN is defined.
interface serial_parity_fsm_if;

  logic start;
  logic bit_in;
  logic bit_valid;
  logic busy;
  logic par_out;
  logic par_valid;
`ifdef SERIAL_PARITY_CHECK_EN
  logic par_err;

  modport master (
    output start, bit_in, bit_valid,
    input  busy, par_out, par_valid, par_err
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, par_out, par_valid, par_err
  );
`else
  modport master (
    output start, bit_in, bit_valid,
    input  busy, par_out, par_valid
  );

  modport slave (
    input  start, bit_in, bit_valid,
    output busy, par_out, par_valid
  );
`endif

endinterface

// File: rtl/bit_counter.sv
// Up-counter with synchronous clear and enable; tc_o flags the count MaxVal.
module bit_counter #(
  parameter int unsigned Width  = 3,
  parameter int unsigned MaxVal = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [Width-1:0] Terminal = Width'(MaxVal);

  logic [Width-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == Terminal);

  // Folding back to zero at the terminal count keeps the register from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/xor2_cell.sv
// 2-input XOR primitive from the gate library.
module xor2_cell (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/serial_parity_fsm.sv
// Serial parity generator; with SERIAL_PARITY_CHECK_EN defined it also checks a
// trailing received parity bit and reports mismatches on par_err.
module serial_parity_fsm
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input logic                clk,
  input logic                rst_n,
  serial_parity_fsm_if.slave bus
);

  localparam int unsigned CntW = $clog2(DATA_W);

  if (DATA_W < DataWMin || DATA_W > DataWMax) begin : g_bad_data_w
    $error("serial_parity_fsm: DATA_W out of range");
  end

  state_e state_q, state_d;
  logic   acc_q, acc_d, acc_xor;
  logic   busy_q, busy_d;
  logic   par_out_q, par_out_d;
  logic   par_valid_q, par_valid_d;
  logic   cnt_clr, cnt_en, cnt_tc;
`ifdef SERIAL_PARITY_CHECK_EN
  logic   err_q, err_d;
`endif

  // Shared accumulate cell: folds data bits in ACCUM, compares parity in CHECK.
  xor2_cell u_xor (
    .a_i (acc_q),
    .b_i (bus.bit_in),
    .y_o (acc_xor)
  );

  bit_counter #(
    .Width  (CntW),
    .MaxVal (DATA_W - 1)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    par_out_d = par_out_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAccum;
          acc_d   = ODD;
          cnt_clr = 1'b1;
        end
      end
      StAccum: begin
        if (bus.bit_valid) begin
          acc_d  = acc_xor;
          cnt_en = 1'b1;
          if (cnt_tc) begin
`ifdef SERIAL_PARITY_CHECK_EN
            state_d = StCheck;
`else
            state_d   = StDone;
            par_out_d = acc_xor;
`endif
          end
        end
      end
      StCheck: begin
`ifdef SERIAL_PARITY_CHECK_EN
        if (bus.bit_valid) begin
          state_d   = StDone;
          par_out_d = acc_q;
          err_d     = acc_xor;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  assign busy_d      = (state_d == StAccum) || (state_d == StCheck);
  assign par_valid_d = (state_d == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= 1'b0;
      busy_q      <= 1'b0;
      par_out_q   <= 1'b0;
      par_valid_q <= 1'b0;
`ifdef SERIAL_PARITY_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
`ifdef SERIAL_PARITY_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
`ifdef SERIAL_PARITY_CHECK_EN
  assign bus.par_err   = err_q;
`endif

endmodule

// File: tb/tb_serial_parity_fsm.sv
// Bench for serial_parity_fsm: an even-parity and an odd-parity instance share the
// same stimulus; expected frame results go through a scoreboard queue.
module tb_serial_parity_fsm;

  localparam int unsigned DW = 8;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam int Lat = DW + 2;
`else
  localparam int Lat = DW + 1;
`endif

  typedef struct {
    logic par_e, par_o, err_e, err_o;
    int   cyc;
  } exp_t;

  typedef struct {
    bit   seen;
    int   cyc;
    logic par_e, par_o, err_e, err_o, pv_o, busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  int   cycle = 0;
  int   pv_e = 0, pv_o = 0;
  int   n_cmp = 0, n_bad = 0;
  exp_t sb[$];

  serial_parity_fsm_if if_e ();
  serial_parity_fsm_if if_o ();

  assign if_e.start = start;
  assign if_e.bit_in = bit_in;
  assign if_e.bit_valid = bit_valid;
  assign if_o.start = start;
  assign if_o.bit_in = bit_in;
  assign if_o.bit_valid = bit_valid;

  serial_parity_fsm #(.DATA_W(DW), .ODD(1'b0)) u_even (.clk(clk), .rst_n(rst_n), .bus(if_e));
  serial_parity_fsm #(.DATA_W(DW), .ODD(1'b1)) u_odd  (.clk(clk), .rst_n(rst_n), .bus(if_o));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) begin
    if (if_e.par_valid) pv_e <= pv_e + 1;
    if (if_o.par_valid) pv_o <= pv_o + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Drives one frame (data MSB first) and pushes its expected result.
  task automatic drive_frame(input logic [7:0] d, input int gap_after, input int gap_len,
                             input logic p, input bit collide, input int restart_at,
                             output logic busy_after_start);
    exp_t e;
    logic x;
    x = ^d;
    e.par_e = x;
    e.par_o = ~x;
    e.err_e = x ^ p;
    e.err_o = ~x ^ p;
    start     = 1'b1;
    bit_valid = collide;
    bit_in    = collide;
    e.cyc     = cycle + Lat + gap_len;
    step();
    start = 1'b0;
    busy_after_start = if_e.busy;
    for (int i = 0; i < 8; i++) begin
      if (i == restart_at) start = 1'b1;
      send_bit(d[7-i]);
      start = 1'b0;
      if (gap_len > 0 && i + 1 == gap_after) repeat (gap_len) step();
    end
`ifdef SERIAL_PARITY_CHECK_EN
    send_bit(p);
`endif
    sb.push_back(e);
  endtask

  // Waits (bounded) for par_valid and gathers both instances' outputs.
  task automatic collect(output obs_t o);
    o.seen = 1'b0;
    o.cyc  = -1;
    for (int k = 0; k < 40; k++) begin
      if (if_e.par_valid === 1'b1) begin
        o.seen = 1'b1;
        o.cyc  = cycle;
        break;
      end
      step();
    end
    o.par_e = if_e.par_out;
    o.par_o = if_o.par_out;
    o.pv_o  = if_o.par_valid;
    o.busy  = if_e.busy;
`ifdef SERIAL_PARITY_CHECK_EN
    o.err_e = if_e.par_err;
    o.err_o = if_o.par_err;
`else
    o.err_e = 1'b0;
    o.err_o = 1'b0;
`endif
  endtask

  task automatic test_reset();
    int busy_bad;
    rst_n = 1'b0;
    repeat (2) step();
    n_cmp++; if (if_e.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", if_e.busy); end
    n_cmp++; if (if_e.par_out !== 1'b0 || if_o.par_out !== 1'b0) begin n_bad++; $display("FAIL reset_par_out got %b/%b want 0/0", if_e.par_out, if_o.par_out); end
    n_cmp++; if (if_e.par_valid !== 1'b0) begin n_bad++; $display("FAIL reset_par_valid got %b want 0", if_e.par_valid); end
`ifdef SERIAL_PARITY_CHECK_EN
    n_cmp++; if (if_e.par_err !== 1'b0) begin n_bad++; $display("FAIL reset_par_err got %b want 0", if_e.par_err); end
`endif
    rst_n = 1'b1;
    busy_bad = 0;
    for (int k = 0; k < 10; k++) begin
      bit_valid = k[0];
      bit_in    = 1'b1;
      step();
      if (if_e.busy !== 1'b0 || if_o.busy !== 1'b0) busy_bad++;
    end
    bit_valid = 1'b0;
    step();
    n_cmp++; if (busy_bad !== 0) begin n_bad++; $display("FAIL idle_busy got %0d busy cycles want 0", busy_bad); end
    n_cmp++; if (pv_e + pv_o !== 0) begin n_bad++; $display("FAIL idle_par_valid got %0d pulses want 0", pv_e + pv_o); end
    n_cmp++; if (if_e.par_out !== 1'b0) begin n_bad++; $display("FAIL idle_par_out got %b want 0", if_e.par_out); end
  endtask

  task automatic test_even();
    logic b1; obs_t o; exp_t e;
    drive_frame(8'b1011_0010, 0, 0, 1'b0, 1'b0, -1, b1);
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL even_busy_rise got %b want 1", b1); end
    collect(o);
    e = sb.pop_front();
    n_cmp++; if (o.seen !== 1'b1 || o.cyc !== e.cyc) begin n_bad++; $display("FAIL even_latency got cyc %0d want %0d", o.cyc, e.cyc); end
    n_cmp++; if (o.par_e !== e.par_e) begin n_bad++; $display("FAIL even_par got %b want %b", o.par_e, e.par_e); end
    n_cmp++; if (o.par_o !== e.par_o || o.pv_o !== 1'b1) begin n_bad++; $display("FAIL even_par_odd_inst got %b/%b want %b/1", o.par_o, o.pv_o, e.par_o); end
    n_cmp++; if (o.busy !== 1'b0) begin n_bad++; $display("FAIL even_busy_done got %b want 0", o.busy); end
    repeat (4) step();
    n_cmp++; if (if_e.par_valid !== 1'b0 || pv_e !== 1) begin n_bad++; $display("FAIL even_pulse got pv=%b count=%0d want 0/1", if_e.par_valid, pv_e); end
    n_cmp++; if (if_e.par_out !== e.par_e) begin n_bad++; $display("FAIL even_par_hold got %b want %b", if_e.par_out, e.par_e); end
  endtask

  task automatic test_odd_gaps();
    logic b1; obs_t o; exp_t e;
    drive_frame(8'b1110_0000, 4, 3, 1'b1, 1'b0, -1, b1);
    collect(o);
    e = sb.pop_front();
    n_cmp++; if (o.seen !== 1'b1 || o.cyc !== e.cyc) begin n_bad++; $display("FAIL gap_latency got cyc %0d want %0d", o.cyc, e.cyc); end
    n_cmp++; if (o.par_o !== e.par_o) begin n_bad++; $display("FAIL gap_par_odd got %b want %b", o.par_o, e.par_o); end
    n_cmp++; if (o.par_e !== e.par_e) begin n_bad++; $display("FAIL gap_par_even got %b want %b", o.par_e, e.par_e); end
    step();
  endtask

`ifdef SERIAL_PARITY_CHECK_EN
  task automatic test_check();
    logic b1; obs_t o; exp_t e;
    for (int r = 0; r < 2; r++) begin
      drive_frame(8'hA5, 0, 0, (r == 0) ? 1'b1 : 1'b0, 1'b0, -1, b1);
      collect(o);
      e = sb.pop_front();
      n_cmp++; if (o.seen !== 1'b1 || o.cyc !== e.cyc) begin n_bad++; $display("FAIL check_latency[%0d] got cyc %0d want %0d", r, o.cyc, e.cyc); end
      n_cmp++; if (o.err_e !== e.err_e) begin n_bad++; $display("FAIL check_err_even[%0d] got %b want %b", r, o.err_e, e.err_e); end
      n_cmp++; if (o.err_o !== e.err_o) begin n_bad++; $display("FAIL check_err_odd[%0d] got %b want %b", r, o.err_o, e.err_o); end
      n_cmp++; if (o.par_e !== e.par_e) begin n_bad++; $display("FAIL check_par[%0d] got %b want %b", r, o.par_e, e.par_e); end
      step();
    end
  endtask
`endif

  task automatic test_start_collide();
    logic b1; obs_t o; exp_t e;
    drive_frame(8'h00, 0, 0, 1'b0, 1'b1, 3, b1);
    collect(o);
    e = sb.pop_front();
    n_cmp++; if (o.seen !== 1'b1 || o.cyc !== e.cyc) begin n_bad++; $display("FAIL collide_latency got cyc %0d want %0d", o.cyc, e.cyc); end
    n_cmp++; if (o.par_e !== e.par_e || o.par_o !== e.par_o) begin n_bad++; $display("FAIL collide_par got %b/%b want %b/%b", o.par_e, o.par_o, e.par_e, e.par_o); end
    step();
  endtask

  task automatic test_reset_mid();
    logic b1; obs_t o; exp_t e; int pv0;
    pv0 = pv_e;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if_e.busy !== 1'b0 || if_o.busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b/%b want 0/0", if_e.busy, if_o.busy); end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (12) step();
    n_cmp++; if (pv_e !== pv0) begin n_bad++; $display("FAIL midreset_no_pulse got %0d pulses want %0d", pv_e, pv0); end
    drive_frame(8'hFF, 0, 0, 1'b0, 1'b0, -1, b1);
    collect(o);
    e = sb.pop_front();
    n_cmp++; if (o.seen !== 1'b1 || o.cyc !== e.cyc) begin n_bad++; $display("FAIL midreset_latency got cyc %0d want %0d", o.cyc, e.cyc); end
    n_cmp++; if (o.par_e !== e.par_e || o.par_o !== e.par_o) begin n_bad++; $display("FAIL midreset_par got %b/%b want %b/%b", o.par_e, o.par_o, e.par_e, e.par_o); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_even();
    test_odd_gaps();
`ifdef SERIAL_PARITY_CHECK_EN
    test_check();
`endif
    test_start_collide();
    test_reset_mid();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_parity_fsm.md
# serial_parity_fsm

Serial parity generator/checker that sits directly downstream of the 2-input XOR primitive and reuses it as its accumulate cell. It accepts a frame of `DATA_W` serial bits under a valid qualifier and folds them into a running XOR. It then publishes the frame parity and, when configured, checks one trailing received parity bit. It is the first sequential consumer of the gate library and feeds the UART/serial-link exercises.

## Interface
- `DATA_W`, 8: data bits per frame; legal range 2..255.
- `ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `bit_in`  in  1  serial data or parity bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `busy`  out  1  a frame is in progress (ACCUM or CHECK).
- `par_out`  out  1  computed parity of the last completed frame.
- `par_valid`  out  1  single-cycle pulse when `par_out` updates.
- `par_err`  out  1  received parity mismatch; present only with `SERIAL_PARITY_CHECK_EN`.
- One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, ACCUM, CHECK (CHECK exists only with the macro), DONE.
- IDLE:
  - `start=1` → ACCUM; accumulator loaded with `ODD`; counter cleared to 0.
  - `bit_valid` is ignored in IDLE.
- ACCUM:
  - Each cycle with `bit_valid=1`: `acc <= acc ^ bit_in`; `cnt <= cnt + 1`.
  - Cycles without `bit_valid` hold `acc` and `cnt` (gaps are allowed, unbounded).
  - On the valid bit with `cnt == DATA_W-1`: go to CHECK if the macro is defined, else DONE.
- CHECK: the next valid bit is the received parity `p`; capture `err = acc ^ p`; go to DONE.
- DONE:
  - `par_out <= acc`; `par_valid=1` for exactly this one cycle.
  - `par_err` is updated in the same cycle (macro builds only).
  - Unconditional return to IDLE.
- `par_out` and `par_err` hold their values until the next DONE.
- `start` outside IDLE is ignored. A new frame cannot be requested until the FSM is back in IDLE.
- Counter width is `$clog2(DATA_W)` bits. It never wraps because the terminal compare ends the frame at `DATA_W-1`.

## Timing
- Reset values: state IDLE, `busy=0`, `par_out=0`, `par_valid=0`, `par_err=0`, `acc=0`, `cnt=0`.
- All outputs are registered; no combinational input-to-output path.
- `busy` rises the cycle after `start` is accepted. It falls in the DONE cycle.
- Same cycle as an accepted `start`, `bit_valid=1`: that bit is NOT counted. The first data bit is accepted in the cycle after `start`.
- Latency with no gaps:
  - Without macro: `start` at cycle 0, data bits at cycles 1..`DATA_W`, `par_valid` at cycle `DATA_W+1`.
  - With macro: parity bit at cycle `DATA_W+1`, `par_valid` at cycle `DATA_W+2`.
- Earliest next `start`: the cycle after DONE. Minimum frame spacing is `DATA_W+2` cycles (`DATA_W+3` with the macro).
- Reset mid-frame: everything returns to reset values immediately; no `par_valid` is issued for the aborted frame.

## Configuration
- `SERIAL_PARITY_CHECK_EN` defined:
  - The CHECK state and the `par_err` port exist.
  - The frame is `DATA_W` data bits plus 1 received parity bit.
  - `par_err=1` when `XOR(data) ^ ODD != p`.
- Undefined:
  - Generator only; no CHECK state, no `par_err` port.
  - DONE follows the last data bit directly.

## Structure
- `serial_parity_pkg`: state encoding localparams (IDLE=2'd0, ACCUM=2'd1, CHECK=2'd2, DONE=2'd3) and the `DATA_W` range-check constants.
- One sub-module: `bit_counter`, a parameterised up-counter with clear, enable and a terminal-count flag.
- The XOR accumulate step instantiates the existing 2-input XOR gate cell.

## Test plan
- Reset/idle: hold `rst_n=0` for 2 cycles, then 10 idle cycles with `bit_valid` toggling → `busy=0`, `par_valid` never asserted, `par_out=0`.
- Even generate: `DATA_W=8`, `ODD=0`, bits 1,0,1,1,0,0,1,0 back-to-back after `start` → `par_out=0`, `par_valid` exactly at cycle 9.
- Odd generate with gaps: `ODD=1`, bits 1,1,1,0,0,0,0,0 with `bit_valid` low for 3 cycles after bit 4 → `par_out=0`; `par_valid` delayed exactly 3 cycles versus the gapless case.
- Check (macro on): data 0xA5 followed by parity bit 1 at `ODD=0` → `par_err=1`; repeat with parity bit 0 → `par_err=0`.
- Start collisions: `start` together with `bit_valid=1`, `bit_in=1`, and `start` re-pulsed mid-frame → first bit not counted; mid-frame `start` ignored; frame ends after 8 further valid bits.
- Reset mid-frame: drop `rst_n` after 4 bits, release, run a fresh frame of all ones → no `par_valid` for the aborted frame; new frame gives `par_out=0`.
